// File: rtl/decode_mod.sv
`default_nettype none
// ============================================================================
// Module      : decode_mod
// Description : RV64 instruction decode stage. Holds the 32x64 integer
//               register file (x0 hard-wired to zero, write-through bypass
//               from writeback), classifies the fetched instruction by
//               opcode, extracts the 20-bit immediate, reads the source
//               operands and latches everything into the ID/EX register.
// Ports       :
//   clk, reset          - pipeline clock, asynchronous active-high reset
//   stackptr            - value loaded into x2 while reset is asserted
//   IFID_instreg/_npc   - fetched instruction and its PC
//   IFID_ready          - fetch outputs valid this cycle
//   EXID_stall          - execute asks decode to hold (load-use)
//   EXIF_branch         - taken branch/jump in execute, flush decode
//   WBID_wbactive/_rd/_rdval - register-file write port
//   IDEX_*, opcode, rs1, rs2, rd, immediate - registered decode results
//   IDIF_stall          - tells fetch to hold its outputs
// Revision    : 1.0 - initial release
// ============================================================================
module decode_mod (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] stackptr,
    input  logic [31:0] IFID_instreg,
    input  logic [63:0] IFID_npc,
    input  logic        IFID_ready,
    input  logic        EXID_stall,
    input  logic        EXIF_branch,
    input  logic        WBID_wbactive,
    input  logic [5:0]  WBID_rd,
    input  logic [63:0] WBID_rdval,
    output logic        IDEX_ready,
    output logic [63:0] IDEX_npc,
    output logic [63:0] opcode,
    output logic [63:0] rs1,
    output logic [63:0] rs2,
    output logic [5:0]  rd,
    output logic [19:0] immediate,
    output logic [5:0]  IDEX_rs1reg,
    output logic [5:0]  IDEX_rs2reg,
    output logic        IDIF_stall
);

    // Major opcodes
    localparam logic [6:0] c_OP_LUI      = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] c_OP_JAL      = 7'b1101111;
    localparam logic [6:0] c_OP_JALR     = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD     = 7'b0000011;
    localparam logic [6:0] c_OP_STORE    = 7'b0100011;
    localparam logic [6:0] c_OP_OPIMM    = 7'b0010011;
    localparam logic [6:0] c_OP_OP       = 7'b0110011;
    localparam logic [6:0] c_OP_OPIMM32  = 7'b0011011;
    localparam logic [6:0] c_OP_OP32     = 7'b0111011;
    localparam logic [6:0] c_OP_SYSTEM   = 7'b1110011;

    // Instruction format classes
    localparam logic [2:0] c_FMT_NONE = 3'd0;
    localparam logic [2:0] c_FMT_R    = 3'd1;
    localparam logic [2:0] c_FMT_I    = 3'd2;
    localparam logic [2:0] c_FMT_S    = 3'd3;
    localparam logic [2:0] c_FMT_B    = 3'd4;
    localparam logic [2:0] c_FMT_U    = 3'd5;
    localparam logic [2:0] c_FMT_J    = 3'd6;

    logic [63:0] r_regs [32];

    logic        r_idex_ready;
    logic [63:0] r_idex_npc;
    logic [63:0] r_opcode;
    logic [63:0] r_rs1;
    logic [63:0] r_rs2;
    logic [5:0]  r_rd;
    logic [19:0] r_imm;
    logic [5:0]  r_rs1reg;
    logic [5:0]  r_rs2reg;

    logic [2:0]  w_fmt;
    logic        w_valid;
    logic [19:0] w_imm;
    logic [5:0]  w_rs1reg;
    logic [5:0]  w_rs2reg;
    logic [5:0]  w_rd;
    logic [63:0] w_opcode;
    logic        w_unused_rd_msb;

    wire [31:0] w_ins = IFID_instreg;

    // The write index is only 5 bits wide in practice.
    assign w_unused_rd_msb = WBID_rd[5];

    // Register read with writeback bypass: a write landing on the same edge
    // as the read is visible to the reader.
    function automatic logic [63:0] f_read(input logic [4:0] idx);
        if (idx == 5'd0) begin
            return 64'd0;
        end else if (WBID_wbactive && (WBID_rd[4:0] == idx)) begin
            return WBID_rdval;
        end else begin
            return r_regs[idx];
        end
    endfunction

    // ------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------
    always_comb begin
        w_fmt   = c_FMT_NONE;
        w_valid = 1'b1;
        case (w_ins[6:0])
            c_OP_LUI, c_OP_AUIPC:                 w_fmt = c_FMT_U;
            c_OP_JAL:                             w_fmt = c_FMT_J;
            c_OP_JALR, c_OP_LOAD, c_OP_OPIMM,
            c_OP_OPIMM32, c_OP_SYSTEM:            w_fmt = c_FMT_I;
            c_OP_BRANCH:                          w_fmt = c_FMT_B;
            c_OP_STORE:                           w_fmt = c_FMT_S;
            c_OP_OP, c_OP_OP32:                   w_fmt = c_FMT_R;
            default:                              w_valid = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    always_comb begin
        w_imm    = 20'd0;
        w_rs1reg = 6'd0;
        w_rs2reg = 6'd0;
        w_rd     = 6'd0;
        case (w_fmt)
            c_FMT_I: begin
                w_imm    = {{8{w_ins[31]}}, w_ins[31:20]};
                w_rs1reg = {1'b0, w_ins[19:15]};
                w_rd     = {1'b0, w_ins[11:7]};
            end
            c_FMT_S: begin
                w_imm    = {{8{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
                w_rs1reg = {1'b0, w_ins[19:15]};
                w_rs2reg = {1'b0, w_ins[24:20]};
            end
            c_FMT_B: begin
                // 13-bit branch offset, bit 0 always zero
                w_imm    = {{7{w_ins[31]}}, w_ins[31], w_ins[7],
                            w_ins[30:25], w_ins[11:8], 1'b0};
                w_rs1reg = {1'b0, w_ins[19:15]};
                w_rs2reg = {1'b0, w_ins[24:20]};
            end
            c_FMT_U: begin
                w_imm = w_ins[31:12];
                w_rd  = {1'b0, w_ins[11:7]};
            end
            c_FMT_J: begin
                // imm[20:1]; imm[0] is implicitly zero and dropped
                w_imm = {w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21]};
                w_rd  = {1'b0, w_ins[11:7]};
            end
            c_FMT_R: begin
                w_rs1reg = {1'b0, w_ins[19:15]};
                w_rs2reg = {1'b0, w_ins[24:20]};
                w_rd     = {1'b0, w_ins[11:7]};
            end
            default: begin
                w_imm = 20'd0;
            end
        endcase
    end

    assign w_opcode = {47'd0, w_ins[31:25], w_ins[14:12], w_ins[6:0]};

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin : p_regfile
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= (i == 2) ? stackptr : 64'd0;
            end
        end else if (WBID_wbactive && (WBID_rd[4:0] != 5'd0)) begin
            r_regs[WBID_rd[4:0]] <= WBID_rdval;
        end
    end

    // ------------------------------------------------------------------
    // ID/EX pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin : p_idex
        if (reset) begin
            r_idex_ready <= 1'b0;
            r_idex_npc   <= 64'd0;
            r_opcode     <= 64'd0;
            r_rs1        <= 64'd0;
            r_rs2        <= 64'd0;
            r_rd         <= 6'd0;
            r_imm        <= 20'd0;
            r_rs1reg     <= 6'd0;
            r_rs2reg     <= 6'd0;
        end else if (EXIF_branch) begin
            r_idex_ready <= 1'b0;
        end else if (EXID_stall) begin
            // Hold, but refresh operands so a writeback finishing during
            // the stall is seen. Unused operands have index 0 and stay 0.
            r_rs1 <= f_read(r_rs1reg[4:0]);
            r_rs2 <= f_read(r_rs2reg[4:0]);
        end else if (IFID_ready && w_valid) begin
            r_idex_ready <= 1'b1;
            r_idex_npc   <= IFID_npc;
            r_opcode     <= w_opcode;
            r_rs1        <= f_read(w_rs1reg[4:0]);
            r_rs2        <= f_read(w_rs2reg[4:0]);
            r_rd         <= w_rd;
            r_imm        <= w_imm;
            r_rs1reg     <= w_rs1reg;
            r_rs2reg     <= w_rs2reg;
        end else begin
            r_idex_ready <= 1'b0;
        end
    end

    assign IDEX_ready  = r_idex_ready;
    assign IDEX_npc    = r_idex_npc;
    assign opcode      = r_opcode;
    assign rs1         = r_rs1;
    assign rs2         = r_rs2;
    assign rd          = r_rd;
    assign immediate   = r_imm;
    assign IDEX_rs1reg = r_rs1reg;
    assign IDEX_rs2reg = r_rs2reg;

    // A flush cancels the hold request towards fetch.
    assign IDIF_stall  = EXID_stall & ~EXIF_branch;

endmodule
`default_nettype wire

// File: tb/tb_decode_mod.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_mod
// Description : Self-checking bench for decode_mod. A reference model of the
//               decoder and register file produces the expected ID/EX
//               contents for every driven cycle; these go into a queue and
//               are popped and compared one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_mod;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] stackptr;
    logic [31:0] IFID_instreg;
    logic [63:0] IFID_npc;
    logic        IFID_ready;
    logic        EXID_stall;
    logic        EXIF_branch;
    logic        WBID_wbactive;
    logic [5:0]  WBID_rd;
    logic [63:0] WBID_rdval;
    logic        IDEX_ready;
    logic [63:0] IDEX_npc;
    logic [63:0] opcode;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [5:0]  rd;
    logic [19:0] immediate;
    logic [5:0]  IDEX_rs1reg;
    logic [5:0]  IDEX_rs2reg;
    logic        IDIF_stall;

    decode_mod dut (
        .clk(clk), .reset(reset), .stackptr(stackptr),
        .IFID_instreg(IFID_instreg), .IFID_npc(IFID_npc), .IFID_ready(IFID_ready),
        .EXID_stall(EXID_stall), .EXIF_branch(EXIF_branch),
        .WBID_wbactive(WBID_wbactive), .WBID_rd(WBID_rd), .WBID_rdval(WBID_rdval),
        .IDEX_ready(IDEX_ready), .IDEX_npc(IDEX_npc), .opcode(opcode),
        .rs1(rs1), .rs2(rs2), .rd(rd), .immediate(immediate),
        .IDEX_rs1reg(IDEX_rs1reg), .IDEX_rs2reg(IDEX_rs2reg), .IDIF_stall(IDIF_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rdy;
        logic [63:0] npc;
        logic [63:0] opc;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [5:0]  rd;
        logic [19:0] imm;
        logic [5:0]  r1;
        logic [5:0]  r2;
    } exp_t;

    exp_t        sb[$];
    exp_t        last;
    exp_t        got;
    exp_t        want;
    logic [63:0] m_regs [32];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic exp_t observe();
        exp_t e;
        e.rdy = IDEX_ready;   e.npc = IDEX_npc;   e.opc = opcode;
        e.rs1 = rs1;          e.rs2 = rs2;        e.rd  = rd;
        e.imm = immediate;    e.r1  = IDEX_rs1reg; e.r2 = IDEX_rs2reg;
        return e;
    endfunction

    // Reference decode of one instruction against the model register file.
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc);
        exp_t        e;
        bit          use1, use2, wrd;
        logic [20:0] jimm;
        logic [12:0] bimm;
        logic [11:0] simm;
        e = '0; use1 = 0; use2 = 0; wrd = 0;
        e.rdy = 1'b1;
        e.npc = pc;
        e.opc = {47'd0, ins[31:25], ins[14:12], ins[6:0]};
        case (ins[6:0])
            7'b0110111, 7'b0010111: begin e.imm = ins[31:12]; wrd = 1; end
            7'b1101111: begin
                jimm  = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                e.imm = jimm[20:1]; wrd = 1;
            end
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0011011, 7'b1110011: begin
                e.imm = 20'($signed(ins[31:20])); use1 = 1; wrd = 1;
            end
            7'b0100011: begin
                simm  = {ins[31:25], ins[11:7]};
                e.imm = 20'($signed(simm)); use1 = 1; use2 = 1;
            end
            7'b1100011: begin
                bimm  = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                e.imm = 20'($signed(bimm)); use1 = 1; use2 = 1;
            end
            7'b0110011, 7'b0111011: begin use1 = 1; use2 = 1; wrd = 1; end
            default: e.rdy = 1'b0;
        endcase
        if (use1) begin e.r1 = {1'b0, ins[19:15]}; e.rs1 = m_regs[ins[19:15]]; end
        if (use2) begin e.r2 = {1'b0, ins[24:20]}; e.rs2 = m_regs[ins[24:20]]; end
        if (wrd)  e.rd = {1'b0, ins[11:7]};
        return e;
    endfunction

    // Drive one cycle of inputs at the falling edge, push the expected
    // ID/EX contents, then move to just after the rising edge.
    task automatic drive(input logic [31:0] ins, input logic [63:0] pc,
                         input logic rdy, input logic st, input logic br,
                         input logic wb, input logic [5:0] wrd, input logic [63:0] wval);
        exp_t e;
        @(negedge clk);
        IFID_instreg = ins; IFID_npc = pc; IFID_ready = rdy;
        EXID_stall = st; EXIF_branch = br;
        WBID_wbactive = wb; WBID_rd = wrd; WBID_rdval = wval;
        if (wb && wrd[4:0] != 5'd0) m_regs[wrd[4:0]] = wval;
        if (br) begin
            e = last; e.rdy = 1'b0;
        end else if (st) begin
            e = last; e.rs1 = m_regs[last.r1[4:0]]; e.rs2 = m_regs[last.r2[4:0]];
        end else if (rdy) begin
            e = model(ins, pc);
        end else begin
            e = last; e.rdy = 1'b0;
        end
        last = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [63:0] sp);
        @(negedge clk);
        reset = 1'b1; stackptr = sp;
        IFID_ready = 0; EXID_stall = 0; EXIF_branch = 0; WBID_wbactive = 0;
        IFID_instreg = '0; IFID_npc = '0; WBID_rd = '0; WBID_rdval = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = (i == 2) ? sp : 64'd0;
        last = '0;
    endtask

    task automatic test_reset();
        do_reset(64'h7FF0);
        got = observe(); vectors++;
        if (got !== exp_t'(0)) begin
            miscompares++; $display("FAIL reset_outputs: got %h want 0", got);
        end
        vectors++;
        if (IDIF_stall !== 1'b0) begin
            miscompares++; $display("FAIL reset_idif_stall: got %b want 0", IDIF_stall);
        end
        // x2 comes up holding the stack pointer
        drive(32'h00010193, 64'h40, 1, 0, 0, 0, 0, 0);   // ADDI x3,x2,0
        got = observe(); want = sb.pop_front(); vectors++;
        if (got !== want || got.rs1 !== 64'h7FF0) begin
            miscompares++; $display("FAIL reset_x2: got %h want %h", got, want);
        end
    endtask

    task automatic test_addi();
        drive(32'h00500093, 64'h1000, 1, 0, 0, 0, 0, 0);
        got = observe(); want = sb.pop_front(); vectors++;
        if (got !== want || got.opc !== 64'h13 || got.rd !== 6'd1 ||
            got.imm !== 20'h00005 || got.r1 !== 6'd0 || got.rs1 !== 64'd0 || !got.rdy) begin
            miscompares++; $display("FAIL addi: got %h want %h", got, want);
        end
    endtask

    task automatic test_wb_add();
        drive(32'h0, 64'h0, 0, 0, 0, 1, 6'd5, 64'hDEAD);
        got = observe(); want = sb.pop_front(); vectors++;
        if (got.rdy !== want.rdy) begin
            miscompares++; $display("FAIL wb_bubble: got %b want %b", got.rdy, want.rdy);
        end
        drive(32'h00528333, 64'h1004, 1, 0, 0, 0, 0, 0);
        got = observe(); want = sb.pop_front(); vectors++;
        if (got !== want || got.rs1 !== 64'hDEAD || got.rs2 !== 64'hDEAD ||
            got.rd !== 6'd6 || got.r1 !== 6'd5 || got.r2 !== 6'd5 || got.imm !== 20'd0) begin
            miscompares++; $display("FAIL add: got %h want %h", got, want);
        end
    endtask

    task automatic test_imm();
        logic [31:0] ins [3];
        logic [19:0] imm_req [3];
        ins[0] = 32'hFFF00093; imm_req[0] = 20'hFFFFF;
        ins[1] = 32'h123450B7; imm_req[1] = 20'h12345;
        ins[2] = 32'hFE50BC23; imm_req[2] = 20'hFFFF8;  // SD x5,-8(x1)
        for (int k = 0; k < 3; k++) begin
            drive(ins[k], 64'h2000 + 64'(k * 4), 1, 0, 0, 0, 0, 0);
            got = observe(); want = sb.pop_front(); vectors++;
            if (got !== want || got.imm !== imm_req[k]) begin
                miscompares++; $display("FAIL imm_%0d: got %h want %h", k, got, want);
            end
        end
    endtask

    task automatic test_opcodes();
        logic [6:0]  ops [14];
        logic [31:0] r;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0011011,
                7'b0111011, 7'b1110011, 7'b1111111, 7'b0001111};
        for (int i = 1; i < 32; i++) begin
            drive(32'h0, 64'h0, 0, 0, 0, 1, 6'(i), {$urandom(), $urandom()});
            got = observe(); want = sb.pop_front(); vectors++;
            if (got.rdy !== want.rdy) begin
                miscompares++; $display("FAIL preload_%0d: got %b want %b", i, got.rdy, want.rdy);
            end
        end
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 0; k < 14; k++) begin
                r = $urandom();
                drive({r[31:7], ops[k]}, {32'h0, $urandom()}, 1, 0, 0, 0, 0, 0);
                got = observe(); want = sb.pop_front(); vectors++;
                if (want.rdy ? (got !== want) : (got.rdy !== 1'b0)) begin
                    miscompares++;
                    $display("FAIL opcode_%b: got %h want %h", ops[k], got, want);
                end
            end
        end
    endtask

    task automatic test_stall();
        drive(32'h00528333, 64'h3000, 1, 0, 0, 0, 0, 0);   // ADD x6,x5,x5
        got = observe(); want = sb.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++; $display("FAIL stall_load: got %h want %h", got, want);
        end
        for (int c = 0; c < 3; c++) begin
            // new fetch data arrives during the hold; x5 is rewritten mid-stall
            drive(32'h00700113 + 32'(c << 20), 64'h3004, 1, 1, 0,
                  c == 1, 6'd5, 64'hBEEF);
            got = observe(); want = sb.pop_front(); vectors++;
            if (got !== want || IDIF_stall !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: got %h idif %b want %h idif 1", c, got, IDIF_stall, want);
            end
        end
        vectors++;
        if (got.rs1 !== 64'hBEEF) begin
            miscompares++; $display("FAIL stall_refresh: got %h want beef", got.rs1);
        end
        drive(32'h00500093, 64'h3008, 1, 0, 0, 0, 0, 0);
        got = observe(); want = sb.pop_front(); vectors++;
        if (got !== want || IDIF_stall !== 1'b0) begin
            miscompares++; $display("FAIL stall_release: got %h want %h", got, want);
        end
    endtask

    task automatic test_branch();
        drive(32'h00500093, 64'h4000, 1, 1, 1, 0, 0, 0);
        got = observe(); want = sb.pop_front(); vectors++;
        if (got.rdy !== 1'b0 || IDIF_stall !== 1'b0) begin
            miscompares++; $display("FAIL branch_flush: got rdy %b idif %b want rdy 0 idif 0", got.rdy, IDIF_stall);
        end
        drive(32'h00500093, 64'h4004, 1, 0, 1, 0, 0, 0);
        got = observe(); want = sb.pop_front(); vectors++;
        if (got.rdy !== want.rdy) begin
            miscompares++; $display("FAIL branch_only: got %b want %b", got.rdy, want.rdy);
        end
    endtask

    task automatic test_x0();
        drive(32'h0, 64'h0, 0, 0, 0, 1, 6'd0, 64'h55);
        got = observe(); want = sb.pop_front(); vectors++;
        if (got.rdy !== 1'b0) begin
            miscompares++; $display("FAIL x0_write: got %b want 0", got.rdy);
        end
        // R-type x7 = x0 + x0 with a same-cycle write to x0 attempted again
        drive(32'h000003B3, 64'h5000, 1, 0, 0, 1, 6'd0, 64'h55);
        got = observe(); want = sb.pop_front(); vectors++;
        if (got !== want || got.rs1 !== 64'd0 || got.rs2 !== 64'd0) begin
            miscompares++; $display("FAIL x0_read: got %h want %h", got, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [4];
        ins = '{32'h00528333, 32'h006283B3, 32'h0003B403, 32'h00838463};
        for (int k = 0; k < 4; k++) begin
            // each write lands on the same edge the next instruction reads it
            drive(ins[k], 64'h6000 + 64'(k * 4), 1, 0, 0, 1, 6'(5 + k), 64'h1111 * 64'(k + 1));
            got = observe(); want = sb.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++; $display("FAIL b2b_%0d: got %h want %h", k, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(32'h00500093, 64'h7000, 1, 0, 0, 0, 0, 0);
        got = observe(); want = sb.pop_front();
        drive(32'h00500093, 64'h7004, 1, 1, 0, 0, 0, 0);
        got = observe(); want = sb.pop_front();
        #2 reset = 1'b1; stackptr = 64'h7FF0;
        #1;
        got = observe(); vectors++;
        if (got !== exp_t'(0)) begin
            miscompares++; $display("FAIL reset_async: got %h want 0", got);
        end
        do_reset(64'h7FF0);
        drive(32'h00010193, 64'h7008, 1, 0, 0, 0, 0, 0);
        got = observe(); want = sb.pop_front(); vectors++;
        if (got !== want || got.rs1 !== 64'h7FF0 || !got.rdy) begin
            miscompares++; $display("FAIL reset_first: got %h want %h", got, want);
        end
    endtask

    initial begin
        reset = 1'b1; stackptr = '0;
        IFID_instreg = '0; IFID_npc = '0; IFID_ready = 0;
        EXID_stall = 0; EXIF_branch = 0;
        WBID_wbactive = 0; WBID_rd = '0; WBID_rdval = '0;
        last = '0;
        test_reset();
        test_addi();
        test_wb_add();
        test_imm();
        test_stall();
        test_branch();
        test_x0();
        test_opcodes();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
